// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants and request-bus layout for the inst/data SRAM-like arbiter.
package sram_req_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  localparam int SRAM_REQ_BUS_WD = 72;

  // req + wr + size + wstrb + addr + wdata, muxed as one word
  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_bus_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit master IDs for outstanding SRAM transactions.
// A pop on an empty FIFO is ignored; a push at full is taken only alongside a pop.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_r;
  logic [DEPTH-1:0] mem;
  logic           push_en;
  logic           pop_en;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates inst/data SRAM-like masters onto one slave with zero added latency.
// Macros: ARB_ROUND_ROBIN_EN (round-robin grant), ARB_PROTOCOL_CHECKS (spurious-response assertion).
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  sram_req_bus_t inst_bus;
  sram_req_bus_t data_bus;
  sram_req_bus_t gnt_bus;

  logic sel;
  logic sel_unlocked;
  logic lock_r;
  logic lock_sel_r;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic fifo_full_block;
  logic addr_accept;
  logic resp_valid;

  assign inst_bus = '{req: inst_req, wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                      addr: inst_addr, wdata: inst_wdata};
  assign data_bus = '{req: data_req, wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_r;

  always_comb begin
    sel_unlocked = ARB_ID_INST;
    if (inst_req && data_req) sel_unlocked = ~rr_last_r;
    else if (data_req)        sel_unlocked = ARB_ID_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset)            rr_last_r <= 1'b1;
    else if (addr_accept) rr_last_r <= sel;
  end
`else
  assign sel_unlocked = data_req ? ARB_ID_DATA : ARB_ID_INST;
`endif

  // A pending un-accepted request pins the grant so the slave sees a stable request
  assign sel     = lock_r ? lock_sel_r : sel_unlocked;
  assign gnt_bus = (sel == ARB_ID_DATA) ? data_bus : inst_bus;

  // A response in the same cycle frees a slot, so a full FIFO can still accept
  assign fifo_full_block = fifo_full && !sram_data_ok;

  assign sram_req    = gnt_bus.req && !fifo_full_block;
  assign sram_wr     = gnt_bus.wr;
  assign sram_size   = gnt_bus.size;
  assign sram_wstrb  = gnt_bus.wstrb;
  assign sram_addr   = gnt_bus.addr;
  assign sram_wdata  = gnt_bus.wdata;

  assign addr_accept  = sram_req && sram_addr_ok;
  assign inst_addr_ok = addr_accept && (sel == ARB_ID_INST);
  assign data_addr_ok = addr_accept && (sel == ARB_ID_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_r     <= 1'b0;
      lock_sel_r <= 1'b0;
    end else if (sram_req && !sram_addr_ok) begin
      lock_r     <= 1'b1;
      lock_sel_r <= sel;
    end else if (addr_accept) begin
      lock_r     <= 1'b0;
    end
  end

  arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (addr_accept),
    .pop   (sram_data_ok),
    .din   (sel),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Responses with nothing outstanding are dropped
  assign resp_valid   = sram_data_ok && !fifo_empty;
  assign inst_data_ok = resp_valid && (fifo_head == ARB_ID_INST);
  assign data_data_ok = resp_valid && (fifo_head == ARB_ID_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

`ifdef ARB_PROTOCOL_CHECKS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(sram_data_ok && fifo_empty))
        else $error("sram_data_ok with no outstanding transaction");
    end
  end
`endif

endmodule
